// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: one full-adder cell is reused over WIDTH cycles, LSB first,
// with a start/busy/done handshake and registered sum, carry-out and signed overflow.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        bit_s   = a_q[0] ^ b_q[0] ^ carry_q;
        bit_c   = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        shifted = {bit_s, res_q};

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : c_in;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = bit_c;
                res_d   = shifted[WIDTH-1:1];
                cnt_d   = cnt_q + CW'(1);
                // On the MSB cycle carry_q is the carry into the MSB, so no separate c_msb flop is needed.
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    sum_d   = shifted;
                    c_out_d = bit_c;
                    ovf_d   = carry_q ^ bit_c;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit and a 4-bit instance are driven with directed,
// random and exhaustive operations and compared against an integer arithmetic reference model.
module tb_serial_adder;

    logic       clk;
    logic       rst;

    logic       start8, c_in8, sub8;
    logic [7:0] a8, b8, sum8;
    logic       busy8, done8, c_out8, ovf8;

    logic       start4, c_in4, sub4;
    logic [3:0] a4, b4, sum4;
    logic       busy4, done4, c_out4, ovf4;

    int checkCount = 0;
    int failCount  = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(c_in8), .sub(sub8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(c_out8), .overflow(ovf8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .c_in(c_in4), .sub(sub4),
        .busy(busy4), .done(done4), .sum(sum4), .c_out(c_out4), .overflow(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int expected);
        checkCount++;
        if (got != expected) begin
            failCount++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, expected);
        end
    endtask

    // Two's-complement arithmetic on plain integers; overflow means the signed result leaves range.
    function automatic void refModel(input int w, input int a, input int b, input int cin,
                                     input int sub, output int s, output int co, output int ov);
        int mask, half, sa, sb, t, r;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        sa   = (a >= half) ? a - (1 << w) : a;
        sb   = (b >= half) ? b - (1 << w) : b;
        if (sub != 0) begin
            s  = (a - b) & mask;
            co = (a >= b) ? 1 : 0;
            r  = sa - sb;
        end else begin
            t  = a + b + cin;
            s  = t & mask;
            co = t >> w;
            r  = sa + sb + cin;
        end
        ov = (r >= half || r < -half) ? 1 : 0;
    endfunction

    task automatic applyStimulus(input int w, input int a, input int b, input int cin, input int sub);
        if (w == 8) begin
            a8 = a[7:0]; b8 = b[7:0]; c_in8 = cin[0]; sub8 = sub[0]; start8 = 1'b1;
        end else begin
            a4 = a[3:0]; b4 = b[3:0]; c_in4 = cin[0]; sub4 = sub[0]; start4 = 1'b1;
        end
    endtask

    task automatic scrambleInputs(input int w);
        if (w == 8) begin
            start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
            c_in8 = 1'($urandom); sub8 = 1'($urandom);
        end else begin
            start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
            c_in4 = 1'($urandom); sub4 = 1'($urandom);
        end
    endtask

    function automatic int getDone(input int w);
        return (w == 8) ? int'(done8) : int'(done4);
    endfunction
    function automatic int getBusy(input int w);
        return (w == 8) ? int'(busy8) : int'(busy4);
    endfunction
    function automatic int getSum(input int w);
        return (w == 8) ? int'(sum8) : int'(sum4);
    endfunction
    function automatic int getCout(input int w);
        return (w == 8) ? int'(c_out8) : int'(c_out4);
    endfunction
    function automatic int getOvf(input int w);
        return (w == 8) ? int'(ovf8) : int'(ovf4);
    endfunction

    task automatic waitDone(input int w, inout int cycles);
        while (getDone(w) == 0 && cycles < 3 * w + 4) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic checkResult(input string tag, input int w, input int a, input int b,
                               input int cin, input int sub);
        int s, co, ov;
        refModel(w, a, b, cin, sub, s, co, ov);
        checkOutput({tag, "_sum"}, getSum(w), s);
        checkOutput({tag, "_cout"}, getCout(w), co);
        checkOutput({tag, "_ovf"}, getOvf(w), ov);
    endtask

    // One complete operation; operands are scrambled right after acceptance to prove they were latched.
    task automatic runOp(input string tag, input int w, input int a, input int b,
                         input int cin, input int sub);
        int cycles;
        @(negedge clk);
        applyStimulus(w, a, b, cin, sub);
        @(negedge clk);
        scrambleInputs(w);
        cycles = 1;
        checkOutput({tag, "_busy"}, getBusy(w), 1);
        waitDone(w, cycles);
        checkOutput({tag, "_latency"}, cycles, w + 1);
        checkResult(tag, w, a, b, cin, sub);
        @(negedge clk);
        checkOutput({tag, "_donepulse"}, getDone(w), 0);
        checkResult({tag, "_hold"}, w, a, b, cin, sub);
    endtask

    initial begin
        int cycles;
        int doneSeen;
        int ra, rb, rc, rs;

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; c_in8 = 1'b0; sub8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; c_in4 = 1'b0; sub4 = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy8", int'(busy8), 0);
        checkOutput("reset_done8", int'(done8), 0);
        checkOutput("reset_sum8", int'(sum8), 0);
        checkOutput("reset_cout8", int'(c_out8), 0);
        checkOutput("reset_ovf8", int'(ovf8), 0);
        checkOutput("reset_sum4", int'(sum4), 0);
        rst = 1'b0;

        runOp("add_wrap", 8, 'hFF, 'h01, 0, 0);
        runOp("add_ovf", 8, 'h7F, 'h01, 0, 0);
        runOp("add_cin", 8, 'h10, 'h20, 1, 0);
        runOp("sub_borrow", 8, 'h05, 'h07, 1, 1);
        runOp("sub_ovf", 8, 'h80, 'h01, 0, 1);
        runOp("sub_equal", 8, 'h5A, 'h5A, 0, 1);

        // Start pulsed three cycles into RUN with new operands must be ignored.
        @(negedge clk);
        applyStimulus(8, 'h12, 'h34, 0, 0);
        @(negedge clk);
        start8 = 1'b0;
        cycles = 1;
        repeat (2) begin
            @(negedge clk);
            cycles++;
        end
        applyStimulus(8, 'hF0, 'hF0, 1, 1);
        @(negedge clk);
        start8 = 1'b0;
        cycles++;
        waitDone(8, cycles);
        checkOutput("run_start_latency", cycles, 9);
        checkResult("run_start", 8, 'h12, 'h34, 0, 0);

        // Start held high through DONE launches a second operation back-to-back.
        @(negedge clk);
        applyStimulus(8, 'hA0, 'h70, 1, 0);
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h11; sub8 = 1'b1; c_in8 = 1'b0;
        cycles = 1;
        waitDone(8, cycles);
        checkOutput("b2b_first_latency", cycles, 9);
        checkResult("b2b_first", 8, 'hA0, 'h70, 1, 0);
        @(negedge clk);
        start8 = 1'b0;
        checkOutput("b2b_no_double_done", int'(done8), 0);
        checkOutput("b2b_busy", int'(busy8), 1);
        cycles = 1;
        waitDone(8, cycles);
        checkOutput("b2b_second_latency", cycles, 9);
        checkResult("b2b_second", 8, 'h33, 'h11, 0, 1);

        // Reset asserted in the fourth RUN cycle aborts the operation without a done pulse.
        @(negedge clk);
        applyStimulus(8, 'h55, 'h0F, 0, 0);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_busy", int'(busy8), 0);
        checkOutput("midrst_done", int'(done8), 0);
        checkOutput("midrst_sum", int'(sum8), 0);
        checkOutput("midrst_cout", int'(c_out8), 0);
        checkOutput("midrst_ovf", int'(ovf8), 0);
        doneSeen = 0;
        repeat (12) begin
            @(negedge clk);
            doneSeen += int'(done8);
        end
        checkOutput("midrst_no_done", doneSeen, 0);

        for (int i = 0; i < 150; i++) begin
            ra = int'($urandom_range(255));
            rb = int'($urandom_range(255));
            rc = int'($urandom_range(1));
            rs = int'($urandom_range(1));
            runOp("rand8", 8, ra, rb, rc, rs);
        end

        for (int ea = 0; ea < 16; ea++)
            for (int eb = 0; eb < 16; eb++)
                for (int ec = 0; ec < 2; ec++)
                    for (int es = 0; es < 2; es++)
                        runOp("exh4", 4, ea, eb, ec, es);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
